// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch, load/store) in front of a single-port word memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed ls-over-if priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_write,
  input  logic [ADDR_WIDTH-1:0] ls_address,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_ready,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_input_data,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_output_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  owner_ls, owner_nx;
  logic                  wr_q, wr_nx;
  logic                  pick_ls;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic [DATA_WIDTH-1:0] wdata_nx;
  logic                  mw_nx;
  logic                  if_rdy_nx, ls_rdy_nx;
  logic [DATA_WIDTH-1:0] if_rd_nx, ls_rd_nx;
  logic                  busy_nx;

  // byte-lane bits are dropped by the word conversion
  logic unused_ok;
  assign unused_ok = ^{if_address[1:0], ls_address[1:0]};

`ifdef MEM_ARB_RR_EN
  logic last_ls, last_ls_nx;

  assign pick_ls = ls_req & (~if_req | ~last_ls);

  always_ff @(posedge clock) begin
    if (!reset_n) last_ls <= 1'b0;
    else          last_ls <= last_ls_nx;
  end

  always_comb begin
    last_ls_nx = last_ls;
    if (state == IDLE && (if_req || ls_req))
      last_ls_nx = pick_ls;
  end
`else
  assign pick_ls = ls_req;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      owner_ls       <= 1'b0;
      wr_q           <= 1'b0;
      mem_address    <= '0;
      mem_input_data <= '0;
      mem_write      <= 1'b0;
      if_ready       <= 1'b0;
      ls_ready       <= 1'b0;
      if_rdata       <= '0;
      ls_rdata       <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      owner_ls       <= owner_nx;
      wr_q           <= wr_nx;
      mem_address    <= addr_nx;
      mem_input_data <= wdata_nx;
      mem_write      <= mw_nx;
      if_ready       <= if_rdy_nx;
      ls_ready       <= ls_rdy_nx;
      if_rdata       <= if_rd_nx;
      ls_rdata       <= ls_rd_nx;
      busy           <= busy_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    owner_nx  = owner_ls;
    wr_nx     = wr_q;
    addr_nx   = mem_address;
    wdata_nx  = mem_input_data;
    mw_nx     = 1'b0;
    if_rdy_nx = 1'b0;
    ls_rdy_nx = 1'b0;
    if_rd_nx  = if_rdata;
    ls_rd_nx  = ls_rdata;
    unique case (state)
      IDLE: begin
        if (if_req || ls_req) begin
          state_nx = ACCESS;
          cnt_nx   = 4'd0;
          owner_nx = pick_ls;
          wr_nx    = pick_ls & ls_write;
          mw_nx    = pick_ls & ls_write;
          if (pick_ls) begin
            addr_nx  = {2'b00, ls_address[ADDR_WIDTH-1:2]};
            wdata_nx = ls_wdata;
          end else begin
            addr_nx  = {2'b00, if_address[ADDR_WIDTH-1:2]};
            wdata_nx = '0;
          end
        end
      end
      ACCESS: begin
        if (cnt == LAST) begin
          state_nx  = DONE;
          cnt_nx    = 4'd0;
          if_rdy_nx = ~owner_ls;
          ls_rdy_nx = owner_ls;
          if (!owner_ls)
            if_rd_nx = mem_output_data;
          else if (!wr_q)
            ls_rd_nx = mem_output_data;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance at latency 1, one at latency 3.
// Expected responses are queued at issue and checked by per-instance monitors.
module tb_mem_arbiter;

  typedef struct packed {
    logic        is_ls;
    logic [31:0] data;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for ready", nm);
  endtask

  // instance A, latency 1
  logic        reset_n;
  logic        if_req, if_ready;
  logic [31:0] if_address, if_rdata;
  logic        ls_req, ls_write, ls_ready;
  logic [31:0] ls_address, ls_wdata, ls_rdata;
  logic [31:0] mem_address, mem_input_data, mem_output_data;
  logic        mem_write, busy;
  logic [31:0] mem_a [0:63];

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_address(if_address),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_write(ls_write), .ls_address(ls_address),
    .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_write(mem_write), .mem_output_data(mem_output_data), .busy(busy)
  );

  assign mem_output_data = mem_a[mem_address[5:0]];
  always @(posedge clock)
    if (mem_write) mem_a[mem_address[5:0]] <= mem_input_data;

  // instance B, latency 3
  logic        b_reset_n;
  logic        b_if_req, b_if_ready;
  logic [31:0] b_if_address, b_if_rdata;
  logic        b_ls_req, b_ls_write, b_ls_ready;
  logic [31:0] b_ls_address, b_ls_wdata, b_ls_rdata;
  logic [31:0] b_mem_address, b_mem_input_data, b_mem_output_data;
  logic        b_mem_write, b_busy;
  logic [31:0] mem_b [0:63];

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
    .clock(clock), .reset_n(b_reset_n),
    .if_req(b_if_req), .if_address(b_if_address),
    .if_ready(b_if_ready), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_write(b_ls_write), .ls_address(b_ls_address),
    .ls_wdata(b_ls_wdata), .ls_ready(b_ls_ready), .ls_rdata(b_ls_rdata),
    .mem_address(b_mem_address), .mem_input_data(b_mem_input_data),
    .mem_write(b_mem_write), .mem_output_data(b_mem_output_data), .busy(b_busy)
  );

  assign b_mem_output_data = mem_b[b_mem_address[5:0]];
  always @(posedge clock)
    if (b_mem_write) mem_b[b_mem_address[5:0]] <= b_mem_input_data;

  exp_t q_a[$];
  exp_t q_b[$];

  int          wr_cnt = 0;
  logic [31:0] wr_addr, wr_data;

  always @(negedge clock)
    if (mem_write) begin
      wr_cnt++;
      wr_addr = mem_address;
      wr_data = mem_input_data;
    end

  always @(negedge clock) begin
    exp_t e;
    if (if_ready || ls_ready) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_ready", {30'd0, if_ready, ls_ready}, 32'd0);
      end else begin
        e = q_a.pop_front();
        chk("a_owner", {31'd0, ls_ready}, {31'd0, e.is_ls});
        chk("a_both_ready", {31'd0, if_ready & ls_ready}, 32'd0);
        chk("a_rdata", e.is_ls ? ls_rdata : if_rdata, e.data);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (b_if_ready || b_ls_ready) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_ready", {30'd0, b_if_ready, b_ls_ready}, 32'd0);
      end else begin
        e = q_b.pop_front();
        chk("b_owner", {31'd0, b_ls_ready}, {31'd0, e.is_ls});
        chk("b_rdata", e.is_ls ? b_ls_rdata : b_if_rdata, e.data);
      end
    end
  end

  task automatic issue_a(input bit is_ls, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_d,
                         output int lat);
    exp_t e;
    int   n;
    e.is_ls = is_ls;
    e.data  = exp_d;
    q_a.push_back(e);
    if (is_ls) begin
      ls_req = 1'b1; ls_write = wr; ls_address = addr; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_address = addr;
    end
    lat = -1;
    n = 0;
    while (lat < 0 && n < 30) begin
      @(negedge clock);
      if (is_ls ? ls_ready : if_ready) lat = n;
      n++;
    end
    if (lat < 0) timeout("a_issue");
    @(posedge clock);
    #1;
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  task automatic wait_ready_a(input int want, input string nm);
    int n, cyc;
    n = 0;
    cyc = 0;
    while (n < want && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (if_ready || ls_ready) n++;
    end
    if (n < want) timeout(nm);
  endtask

  initial begin
    int    lat, w0, n;
    logic  pat [4];
    exp_t  e;

    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'h1000_0000 + i;
      mem_b[i] = 32'h2000_0000 + i;
    end
    mem_a[0] = 32'hA0A0_A0A0;
    mem_a[1] = 32'hA1A1_A1A1;
    mem_a[2] = 32'h0000_0013;
    mem_a[8] = 32'h0000_0088;
    mem_a[9] = 32'h0000_0099;
    mem_b[5] = 32'h0000_0055;

    // reset with both requests asserted
    reset_n = 1'b0; b_reset_n = 1'b0;
    if_req = 1'b1; if_address = 32'h40;
    ls_req = 1'b1; ls_write = 1'b1; ls_address = 32'h44; ls_wdata = 32'h1234_5678;
    b_if_req = 1'b0; b_if_address = '0;
    b_ls_req = 1'b0; b_ls_write = 1'b0; b_ls_address = '0; b_ls_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_write_cnt", 32'(wr_cnt), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_input_data", mem_input_data, 32'd0);
    chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
    chk("rst_b_busy", {31'd0, b_busy}, 32'd0);
    @(posedge clock);
    #1;
    if_req = 1'b0; ls_req = 1'b0;
    reset_n = 1'b1; b_reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // contention from reset: continuous if(0x0) and ls load(0x20)
`ifdef MEM_ARB_RR_EN
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;
`else
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b1; pat[3] = 1'b1;
`endif
    for (int k = 0; k < 4; k++) begin
      e.is_ls = pat[k];
      e.data  = pat[k] ? 32'h0000_0088 : 32'hA0A0_A0A0;
      q_a.push_back(e);
    end
    if_req = 1'b1; if_address = 32'h0;
    ls_req = 1'b1; ls_write = 1'b0; ls_address = 32'h20;
    wait_ready_a(4, "contention");
    @(posedge clock);
    #1;
    if_req = 1'b0; ls_req = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("contention_drained", 32'(q_a.size()), 32'd0);

    // single fetch
    issue_a(1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0000_0013, lat);
    chk("fetch_latency", 32'(lat), 32'd2);
    chk("fetch_mem_address", mem_address, 32'h2);
    chk("fetch_if_rdata", if_rdata, 32'h0000_0013);

    // store leaves ls_rdata at the last load value
    w0 = wr_cnt;
    issue_a(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0000_0088, lat);
    chk("store_latency", 32'(lat), 32'd2);
    chk("store_write_pulses", 32'(wr_cnt - w0), 32'd1);
    chk("store_mem_address", wr_addr, 32'h4);
    chk("store_mem_data", wr_data, 32'hDEAD_BEEF);
    chk("store_committed", mem_a[4], 32'hDEAD_BEEF);
    chk("store_mem_write_low", {31'd0, mem_write}, 32'd0);

    // misaligned load reads back the stored word
    issue_a(1'b1, 1'b0, 32'h13, 32'h0, 32'hDEAD_BEEF, lat);
    chk("load_latency", 32'(lat), 32'd2);

    // back-to-back fetch, address changes at the ready edge
    e.is_ls = 1'b0; e.data = 32'hA0A0_A0A0; q_a.push_back(e);
    e.is_ls = 1'b0; e.data = 32'hA1A1_A1A1; q_a.push_back(e);
    if_req = 1'b1; if_address = 32'h0;
    wait_ready_a(1, "b2b_first");
    @(posedge clock);
    #1;
    if_address = 32'h4;
    wait_ready_a(1, "b2b_second");
    @(posedge clock);
    #1;
    if_req = 1'b0;
    chk("b2b_if_rdata", if_rdata, 32'hA1A1_A1A1);

    // latency-3 instance: reset in the second ACCESS cycle
    @(posedge clock);
    #1;
    b_ls_req = 1'b1; b_ls_write = 1'b0; b_ls_address = 32'h14;
    @(negedge clock);
    @(negedge clock);
    chk("b_busy_access", {31'd0, b_busy}, 32'd1);
    @(posedge clock);
    #1;
    b_reset_n = 1'b0;
    b_ls_req = 1'b0;
    @(posedge clock);
    #1;
    b_reset_n = 1'b1;
    @(negedge clock);
    chk("b_busy_after_reset", {31'd0, b_busy}, 32'd0);
    chk("b_ready_after_reset", {30'd0, b_if_ready, b_ls_ready}, 32'd0);
    chk("b_rdata_after_reset", b_ls_rdata, 32'd0);
    repeat (4) @(posedge clock);
    #1;

    // reissued load completes normally
    e.is_ls = 1'b1; e.data = 32'h0000_0055; q_b.push_back(e);
    b_ls_req = 1'b1;
    lat = -1;
    n = 0;
    while (lat < 0 && n < 30) begin
      @(negedge clock);
      if (b_ls_ready) lat = n;
      n++;
    end
    if (lat < 0) timeout("b_reissue");
    @(posedge clock);
    #1;
    b_ls_req = 1'b0;
    chk("b_reissue_latency", 32'(lat), 32'd4);
    chk("b_mem_address", b_mem_address, 32'h5);

    repeat (4) @(posedge clock);
    chk("a_queue_empty", 32'(q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
